// File: rtl/wb_byte_lane_sequencer.sv
// Splits one 32-bit Wishbone classic access into single-lane accesses, lowest lane first,
// merging read bytes and returning one termination. Optional watchdog: WB_SEQ_TIMEOUT_EN.
module wb_byte_lane_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_cyc_i,
  input  logic                  s_stb_i,
  input  logic                  s_we_i,
  input  logic [ADDR_WIDTH-1:0] s_adr_i,
  input  logic [3:0]            s_sel_i,
  input  logic [31:0]           s_dat_i,
  output logic [31:0]           s_dat_o,
  output logic                  s_ack_o,
  output logic                  s_err_o,
  output logic                  s_rty_o,
  output logic                  m_cyc_o,
  output logic                  m_stb_o,
  output logic                  m_we_o,
  output logic [ADDR_WIDTH-1:0] m_adr_o,
  output logic [3:0]            m_sel_o,
  output logic [31:0]           m_dat_o,
  input  logic [31:0]           m_dat_i,
  input  logic                  m_ack_i,
  input  logic                  m_err_i,
  input  logic                  m_rty_i
);

  typedef enum logic [1:0] {StIdle, StLane, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            pend_q, pend_d, pend_nx;
  logic [31:0]           acc_q, acc_d, acc_nx;
  logic [ADDR_WIDTH-3:0] wadr_q, wadr_d;
  logic                  m_cyc_q, m_cyc_d, m_stb_q, m_stb_d, m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_adr_q, m_adr_d;
  logic [3:0]            m_sel_q, m_sel_d;
  logic [31:0]           m_dat_q, m_dat_d, s_dat_q, s_dat_d;
  logic                  s_ack_q, s_ack_d, s_err_q, s_err_d, s_rty_q, s_rty_d;
  logic [1:0]            lane_nx;
  logic                  timeout;

  // Word access only: the low address bits are replaced by the lane number.
  logic unused_adr;
  assign unused_adr = ^s_adr_i[1:0];

  function automatic logic [1:0] low_lane(input logic [3:0] p);
    if (p[0]) return 2'd0;
    if (p[1]) return 2'd1;
    if (p[2]) return 2'd2;
    return 2'd3;
  endfunction

`ifdef WB_SEQ_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign timeout = (cnt_inc == 17'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    acc_nx = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (m_sel_q[i] && !m_we_q) acc_nx[8*i +: 8] = m_dat_i[8*i +: 8];
    end
    pend_nx = pend_q & ~m_sel_q;
    lane_nx = (state_q == StIdle) ? low_lane(s_sel_i) : low_lane(pend_nx);
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    wadr_d  = wadr_q;
    m_we_d  = m_we_q;
    m_dat_d = m_dat_q;
    m_adr_d = m_adr_q;
    m_cyc_d = 1'b0;
    m_stb_d = 1'b0;
    m_sel_d = 4'b0;
    s_ack_d = 1'b0;
    s_err_d = 1'b0;
    s_rty_d = 1'b0;
    s_dat_d = 32'b0;
`ifdef WB_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (s_cyc_i && s_stb_i) begin
          wadr_d  = s_adr_i[ADDR_WIDTH-1:2];
          m_we_d  = s_we_i;
          m_dat_d = s_dat_i;
          pend_d  = s_sel_i;
          acc_d   = 32'b0;
          if (s_sel_i != 4'b0) begin
            state_d = StLane;
            m_cyc_d = 1'b1;
            m_stb_d = 1'b1;
            m_sel_d = 4'b0001 << lane_nx;
            m_adr_d = {s_adr_i[ADDR_WIDTH-1:2], lane_nx};
`ifdef WB_SEQ_TIMEOUT_EN
            cnt_d   = 16'd0;
`endif
          end else begin
            state_d = StResp;
            s_ack_d = 1'b1;
          end
        end
      end
      StLane: begin
        if (!s_cyc_i) begin
          state_d = StIdle;
        end else if (m_err_i) begin
          state_d = StResp;
          s_err_d = 1'b1;
          s_dat_d = acc_q;
        end else if (m_rty_i) begin
          state_d = StResp;
          s_rty_d = 1'b1;
          s_dat_d = acc_q;
        end else if (m_ack_i) begin
          acc_d  = acc_nx;
          pend_d = pend_nx;
          if (pend_nx != 4'b0) begin
            m_cyc_d = 1'b1;
            m_stb_d = 1'b1;
            m_sel_d = 4'b0001 << lane_nx;
            m_adr_d = {wadr_q, lane_nx};
`ifdef WB_SEQ_TIMEOUT_EN
            cnt_d   = 16'd0;
`endif
          end else begin
            state_d = StResp;
            s_ack_d = 1'b1;
            s_dat_d = acc_nx;
          end
        end else if (timeout) begin
          state_d = StResp;
          s_err_d = 1'b1;
          s_dat_d = acc_q;
        end else begin
          m_cyc_d = 1'b1;
          m_stb_d = 1'b1;
          m_sel_d = m_sel_q;
`ifdef WB_SEQ_TIMEOUT_EN
          cnt_d   = cnt_inc[15:0];
`endif
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pend_q  <= 4'b0;
      acc_q   <= 32'b0;
      wadr_q  <= '0;
      m_cyc_q <= 1'b0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_sel_q <= 4'b0;
      m_dat_q <= 32'b0;
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      s_rty_q <= 1'b0;
      s_dat_q <= 32'b0;
`ifdef WB_SEQ_TIMEOUT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      wadr_q  <= wadr_d;
      m_cyc_q <= m_cyc_d;
      m_stb_q <= m_stb_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_sel_q <= m_sel_d;
      m_dat_q <= m_dat_d;
      s_ack_q <= s_ack_d;
      s_err_q <= s_err_d;
      s_rty_q <= s_rty_d;
      s_dat_q <= s_dat_d;
`ifdef WB_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign s_dat_o = s_dat_q;
  assign s_ack_o = s_ack_q;
  assign s_err_o = s_err_q;
  assign s_rty_o = s_rty_q;
  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_stb_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_sel_o = m_sel_q;
  assign m_dat_o = m_dat_q;

endmodule

// File: doc/wb_byte_lane_sequencer.md
# wb_byte_lane_sequencer

Splits one 32-bit Wishbone classic access with any `sel` pattern into successive single-lane accesses, lowest lane first. It sits directly upstream of the 32-to-8 Wishbone converter, which maps exactly one byte lane per access from `adr[1:0]`. Read bytes are merged back into one 32-bit word, and the upstream master receives a single termination.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width on both sides.
- `TIMEOUT_CYCLES`, 255: per-lane watchdog limit in cycles; used only with `WB_SEQ_TIMEOUT_EN`; range 1..65535.

Ports:
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `s_cyc_i`, `s_stb_i`, `s_we_i` in 1 each: upstream 32-bit cycle, strobe and write-enable.
- `s_adr_i` in `ADDR_WIDTH`: upstream address; bits [1:0] are ignored (word access).
- `s_sel_i` in 4: upstream byte selects.
- `s_dat_i` in 32: upstream write data.
- `s_dat_o` out 32: merged read data.
- `s_ack_o`, `s_err_o`, `s_rty_o` out 1 each: upstream termination, one-cycle pulses.
- `m_cyc_o`, `m_stb_o`, `m_we_o` out 1 each: downstream cycle, strobe and write-enable (toward the converter).
- `m_adr_o` out `ADDR_WIDTH`: downstream address = {latched word address, lane[1:0]}.
- `m_sel_o` out 4: one-hot lane select.
- `m_dat_o` out 32: latched full write word; the converter extracts the lane.
- `m_dat_i` in 32: downstream read data, returned in the selected lane.
- `m_ack_i`, `m_err_i`, `m_rty_i` in 1 each: downstream termination.

## Operation
- All outputs are registered. Reset value of every output is 0; state resets to IDLE and the pending mask and accumulator are cleared.
- IDLE: when `s_cyc_i & s_stb_i` is seen, latch the address, `we`, `sel` (as the pending mask) and write data, and clear the accumulator.
  - pending ≠ 0: go to LANE.
  - pending = 0: go to RESP with ack and `s_dat_o` = 0, with no downstream access.
- LANE: drive `m_cyc_o` = `m_stb_o` = 1 with the lane L = lowest set bit of pending, `m_sel_o` = 1<<L, `m_adr_o[1:0]` = L.
  - On `m_ack_i`: for reads, accumulator[8L+7:8L] ← `m_dat_i[8L+7:8L]`; clear bit L in pending.
  - Pending still nonzero: stay in LANE and present the next lane the following cycle with `m_stb_o` held high.
  - Pending now zero: go to RESP with ack.
- Downstream `m_err_i` or `m_rty_i` during LANE: abort the remaining lanes and go to RESP with err or rty respectively. If several terminations assert together, priority is err > rty > ack.
- RESP: lasts one cycle.
  - `m_cyc_o` = `m_stb_o` = 0.
  - Exactly one of `s_ack_o`/`s_err_o`/`s_rty_o` = 1.
  - `s_dat_o` = accumulator; unselected or unread lanes are 0.
  - Next state is IDLE. A still-asserted `s_stb_i` in IDLE starts a new request.
- Upstream abort: if `s_cyc_i` = 0 in LANE, drop `m_cyc_o`/`m_stb_o` on the next cycle and return to IDLE with no upstream termination. A late downstream ack is ignored.
- `s_dat_o` is valid only during the termination pulse and is 0 at all other times.

## Timing
- Request sampled in IDLE at cycle 0 → `m_stb_o` high from cycle 1.
- Zero-wait slave (ack in the same cycle as stb): one cycle per lane. N lanes → upstream termination at cycle N+1.
- Wait states add cycles 1:1 to the lane they occur in.
- sel = 0 → `s_ack_o` at cycle 1.
- Minimum spacing between consecutive upstream requests: RESP + IDLE = 2 cycles.
- Reset asserted mid-operation → all outputs are 0 on the next edge; the access in progress is dropped.

## Configuration
- `WB_SEQ_TIMEOUT_EN` defined:
  - A per-lane counter clears on entry to each lane and increments each LANE cycle without a termination.
  - When it reaches `TIMEOUT_CYCLES`, abort and go to RESP with `s_err_o`.
  - `s_dat_o` carries the bytes collected so far.
- Undefined: no counter is instantiated, and LANE waits indefinitely for a termination.

## Test plan
- Read, sel 1111, adr 0x100, zero-wait slave returning 0x11/0x22/0x33/0x44 per lane → `m_adr_o` 0x100, 0x101, 0x102, 0x103 with sel 0001/0010/0100/1000; `s_dat_o` = 0x44332211 with `s_ack_o` at cycle 5.
- Write, sel 0101, dat 0xAABBCCDD, adr 0x200 → two downstream writes: 0x200/sel 0001 and 0x202/sel 0100, each with `m_dat_o` = 0xAABBCCDD; one `s_ack_o` afterwards.
- sel 0000 → `s_ack_o` at cycle 1 with `s_dat_o` = 0; `m_stb_o` never asserted.
- Read, sel 1111, `m_err_i` on the 2nd lane → no 3rd or 4th lane issued; `s_err_o` pulses once and `s_ack_o` stays 0; `s_dat_o[7:0]` = byte 0, rest 0.
- `WB_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16, silent slave → `m_stb_o` high for 16 cycles, then a one-cycle `s_err_o`.
- `rst_i` during the 3rd lane of a 4-lane read → all outputs 0 next cycle; a following sel 0001 read completes normally.
